cpu_fabric_op_bridge: RTL and testbench

- CPU-side handshake stage that sits directly upstream and downstream of a column of W_CPU_IO tiles.
- Accepts a two-operand request from the RISC-V core and drives it onto the tiles' OPA/OPB pins, 4 bits per tile.
- Waits a programmable number of fabric cycles, then captures the tiles' RES0/RES1/RES2 outputs and returns them as a response with valid/ready.
- Single-outstanding custom-operation unit.

---
 rtl/cpu_fabric_pkg.sv | 17 +
 rtl/cpu_fabric_lat_counter.sv | 28 ++
 rtl/cpu_fabric_op_bridge.sv | 170 +++++++++++++++++
 tb/tb_cpu_fabric_op_bridge.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_fabric_pkg.sv
// Shared types and helpers for the CPU-to-fabric custom-operation bridge.
package cpu_fabric_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int TILE_NIB = 4;

  // Base bit of tile k's nibble within an operand/result bus.
  function automatic int tile_base(input int k);
    return TILE_NIB * k;
  endfunction

endpackage

// File: rtl/cpu_fabric_lat_counter.sv
// Latency down-counter: loads on accept and counts down to zero.
// Holds at zero, so a load of 0 reads as expired immediately.
module cpu_fabric_lat_counter #(
  parameter int LAT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [LAT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [LAT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - LAT_W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/cpu_fabric_op_bridge.sv
// Single-outstanding bridge: drives CPU operands onto a W_CPU_IO tile column,
// waits lat_q cycles, then returns the tile results. Optional perf counters
// are built when CPU_FABRIC_OP_PERF_EN is defined.
//
//   state | meaning
//   IDLE  | ready for a request
//   WAIT  | operands on the fabric, latency counter running
//   RESP  | results captured, rsp_valid held until rsp_ready
module cpu_fabric_op_bridge
  import cpu_fabric_pkg::*;
#(
  parameter int NUM_TILES = 8,
  parameter int LAT_W     = 4,
  parameter int LAT_RST   = 1
) (
  input  logic                        UserCLK,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [TILE_NIB*NUM_TILES-1:0] req_opa,
  input  logic [TILE_NIB*NUM_TILES-1:0] req_opb,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [TILE_NIB*NUM_TILES-1:0] rsp_res0,
  output logic [TILE_NIB*NUM_TILES-1:0] rsp_res1,
  output logic [TILE_NIB*NUM_TILES-1:0] rsp_res2,
  input  logic                        cfg_we,
  input  logic [LAT_W-1:0]            cfg_lat,
  output logic [LAT_W-1:0]            lat_q,
  output logic [TILE_NIB*NUM_TILES-1:0] fabric_opa,
  output logic [TILE_NIB*NUM_TILES-1:0] fabric_opb,
  input  logic [TILE_NIB*NUM_TILES-1:0] fabric_res0,
  input  logic [TILE_NIB*NUM_TILES-1:0] fabric_res1,
  input  logic [TILE_NIB*NUM_TILES-1:0] fabric_res2
`ifdef CPU_FABRIC_OP_PERF_EN
  ,
  output logic [31:0]                 op_count,
  output logic [31:0]                 busy_cycles
`endif
);

  localparam int OP_W = TILE_NIB * NUM_TILES;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_capture;
  logic             w_rsp_done;
  logic             w_cnt_zero;
  logic [LAT_W-1:0] r_lat;
  logic [OP_W-1:0]  r_opa;
  logic [OP_W-1:0]  r_opb;
  logic [OP_W-1:0]  r_res0;
  logic [OP_W-1:0]  r_res1;
  logic [OP_W-1:0]  r_res2;
  logic             r_rsp_valid;

  always_ff @(posedge UserCLK) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (w_cnt_zero) begin
          w_capture   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_rsp_done  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign req_ready = (r_state == IDLE);

  // The counter takes lat_q as it stands at accept; later cfg writes only
  // affect the next operation.
  cpu_fabric_lat_counter #(
    .LAT_W(LAT_W)
  ) u_lat_counter (
    .i_clk      (UserCLK),
    .i_reset    (reset),
    .i_load     (w_accept),
    .i_load_val (r_lat),
    .i_dec      (r_state == WAIT),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge UserCLK) begin
    if (reset) begin
      r_lat       <= LAT_W'(LAT_RST);
      r_opa       <= '0;
      r_opb       <= '0;
      r_res0      <= '0;
      r_res1      <= '0;
      r_res2      <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      if (cfg_we) begin
        r_lat <= cfg_lat;
      end
      // Operands stay on the fabric after completion so tiles see stable inputs.
      if (w_accept) begin
        for (int k = 0; k < NUM_TILES; k++) begin
          r_opa[tile_base(k) +: TILE_NIB] <= req_opa[tile_base(k) +: TILE_NIB];
          r_opb[tile_base(k) +: TILE_NIB] <= req_opb[tile_base(k) +: TILE_NIB];
        end
      end
      if (w_capture) begin
        r_res0      <= fabric_res0;
        r_res1      <= fabric_res1;
        r_res2      <= fabric_res2;
        r_rsp_valid <= 1'b1;
      end else if (w_rsp_done) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign lat_q      = r_lat;
  assign fabric_opa = r_opa;
  assign fabric_opb = r_opb;
  assign rsp_res0   = r_res0;
  assign rsp_res1   = r_res1;
  assign rsp_res2   = r_res2;
  assign rsp_valid  = r_rsp_valid;

`ifdef CPU_FABRIC_OP_PERF_EN
  logic [31:0] r_op_count;
  logic [31:0] r_busy_cycles;

  always_ff @(posedge UserCLK) begin
    if (reset) begin
      r_op_count    <= '0;
      r_busy_cycles <= '0;
    end else begin
      if (w_rsp_done && (r_op_count != '1)) begin
        r_op_count <= r_op_count + 32'd1;
      end
      if ((r_state != IDLE) && (r_busy_cycles != '1)) begin
        r_busy_cycles <= r_busy_cycles + 32'd1;
      end
    end
  end

  assign op_count    = r_op_count;
  assign busy_cycles = r_busy_cycles;
`endif

endmodule

// File: tb/tb_cpu_fabric_op_bridge.sv
// Scoreboard bench for cpu_fabric_op_bridge; a small tile model drives the
// fabric results from the operands the bridge presents.
module tb_cpu_fabric_op_bridge;

  localparam int NUM_TILES = 8;
  localparam int LAT_W     = 4;
  localparam int LAT_RST   = 1;
  localparam int OP_W      = 4 * NUM_TILES;

  logic              UserCLK = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [OP_W-1:0]   req_opa = '0;
  logic [OP_W-1:0]   req_opb = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [OP_W-1:0]   rsp_res0, rsp_res1, rsp_res2;
  logic              cfg_we = 1'b0;
  logic [LAT_W-1:0]  cfg_lat = '0;
  logic [LAT_W-1:0]  lat_q;
  logic [OP_W-1:0]   fabric_opa, fabric_opb;
  logic [OP_W-1:0]   fabric_res0, fabric_res1, fabric_res2;
`ifdef CPU_FABRIC_OP_PERF_EN
  logic [31:0]       op_count, busy_cycles;
`endif

  cpu_fabric_op_bridge #(
    .NUM_TILES(NUM_TILES), .LAT_W(LAT_W), .LAT_RST(LAT_RST)
  ) dut (
    .UserCLK(UserCLK), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opa(req_opa), .req_opb(req_opb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res0(rsp_res0), .rsp_res1(rsp_res1), .rsp_res2(rsp_res2),
    .cfg_we(cfg_we), .cfg_lat(cfg_lat), .lat_q(lat_q),
    .fabric_opa(fabric_opa), .fabric_opb(fabric_opb),
    .fabric_res0(fabric_res0), .fabric_res1(fabric_res1), .fabric_res2(fabric_res2)
`ifdef CPU_FABRIC_OP_PERF_EN
    , .op_count(op_count), .busy_cycles(busy_cycles)
`endif
  );

  always #5 UserCLK = ~UserCLK;

  // Tile model: 0 = arithmetic on presented operands, 1 = fixed words, 2 = noise.
  int          res_mode = 0;
  logic [31:0] noise0 = '0, noise1 = '0, noise2 = '0;

  always_comb begin
    fabric_res0 = fabric_opa + fabric_opb;
    fabric_res1 = fabric_opa ^ fabric_opb;
    fabric_res2 = fabric_opa - fabric_opb;
    if (res_mode == 1) begin
      fabric_res0 = 32'hCAFEF00D;
      fabric_res1 = 32'h0BADBEEF;
      fabric_res2 = 32'h13579BDF;
    end else if (res_mode == 2) begin
      fabric_res0 = noise0;
      fabric_res1 = noise1;
      fabric_res2 = noise2;
    end
  end

  typedef struct packed {
    logic [OP_W-1:0] r0;
    logic [OP_W-1:0] r1;
    logic [OP_W-1:0] r2;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    if (res_mode == 1) begin
      e.r0 = 32'hCAFEF00D; e.r1 = 32'h0BADBEEF; e.r2 = 32'h13579BDF;
    end else begin
      e.r0 = a + b; e.r1 = a ^ b; e.r2 = a - b;
    end
    return e;
  endfunction

  // Drive a request at a negedge in IDLE; returns at the negedge of cycle T+1.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    req_opa = a; req_opb = b; req_valid = 1'b1;
    sb.push_back(model(a, b));
    @(negedge UserCLK);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int start, output int n);
    n = start;
    while (!rsp_valid && n < 60) begin
      @(negedge UserCLK);
      n++;
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge UserCLK);
    rsp_ready = 1'b0;
  endtask

  task automatic set_lat(input logic [LAT_W-1:0] v);
    cfg_we = 1'b1; cfg_lat = v;
    @(negedge UserCLK);
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge UserCLK);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (lat_q !== LAT_W'(LAT_RST)) begin errors++; $display("FAIL reset_lat_q got %0d want %0d", lat_q, LAT_RST); end
    checks++; if ({fabric_opa, fabric_opb} !== '0) begin errors++; $display("FAIL reset_fabric_ops got %h want 0", {fabric_opa, fabric_opb}); end
    checks++; if ({rsp_res0, rsp_res1, rsp_res2} !== '0) begin errors++; $display("FAIL reset_rsp_res got %h want 0", {rsp_res0, rsp_res1, rsp_res2}); end
    reset = 1'b0;
    @(negedge UserCLK);
  endtask

  task automatic test_basic();
    int n;
    exp_t e;
    res_mode = 1;
    issue(32'h12345678, 32'h9ABCDEF0);
    checks++; if (fabric_opa !== 32'h12345678) begin errors++; $display("FAIL basic_fabric_opa got %h want 12345678", fabric_opa); end
    checks++; if (fabric_opb !== 32'h9ABCDEF0) begin errors++; $display("FAIL basic_fabric_opb got %h want 9abcdef0", fabric_opb); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL basic_req_ready_busy got %b want 0", req_ready); end
    wait_rsp(1, n);
    checks++; if (n != 3) begin errors++; $display("FAIL basic_latency got %0d want 3", n); end
    e = sb.pop_front();
    checks++; if ({rsp_res0, rsp_res1, rsp_res2} !== e) begin errors++; $display("FAIL basic_result got %h want %h", {rsp_res0, rsp_res1, rsp_res2}, e); end
    handshake();
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL basic_after_hs got %b want 01", {rsp_valid, req_ready}); end
    res_mode = 0;
  endtask

  task automatic test_lat0();
    int n;
    exp_t e;
    set_lat(0);
    issue(32'd5, 32'd7);
    wait_rsp(1, n);
    checks++; if (n != 2) begin errors++; $display("FAIL lat0_latency got %0d want 2", n); end
    checks++; if (rsp_res0 !== 32'd12) begin errors++; $display("FAIL lat0_res0 got %0d want 12", rsp_res0); end
    e = sb.pop_front();
    checks++; if ({rsp_res0, rsp_res1, rsp_res2} !== e) begin errors++; $display("FAIL lat0_result got %h want %h", {rsp_res0, rsp_res1, rsp_res2}, e); end
    handshake();
  endtask

  task automatic test_backpressure();
    int n;
    int extra;
    exp_t e;
    set_lat(1);
    issue(32'hA5A50F0F, 32'h01020304);
    wait_rsp(1, n);
    checks++; if (n != 3) begin errors++; $display("FAIL bp_latency got %0d want 3", n); end
    e = sb.pop_front();
    res_mode = 2;
    for (int i = 0; i < 5; i++) begin
      noise0 = $urandom; noise1 = $urandom; noise2 = $urandom;
      @(negedge UserCLK);
      checks++; if ({rsp_valid, req_ready} !== 2'b10) begin errors++; $display("FAIL bp_hold_flags[%0d] got %b want 10", i, {rsp_valid, req_ready}); end
      checks++; if ({rsp_res0, rsp_res1, rsp_res2} !== e) begin errors++; $display("FAIL bp_hold_result[%0d] got %h want %h", i, {rsp_res0, rsp_res1, rsp_res2}, e); end
    end
    handshake();
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL bp_after_hs got %b want 01", {rsp_valid, req_ready}); end
    rsp_ready = 1'b1;
    extra = 0;
    repeat (4) begin
      @(negedge UserCLK);
      if (rsp_valid) extra++;
    end
    rsp_ready = 1'b0;
    checks++; if (extra != 0) begin errors++; $display("FAIL bp_single_hs got %0d extra valid cycles want 0", extra); end
    res_mode = 0;
  endtask

  task automatic test_cfg_midflight();
    int n;
    exp_t e;
    set_lat(2);
    issue(32'h00000011, 32'h00000022);
    cfg_we = 1'b1; cfg_lat = 4'd9;
    @(negedge UserCLK);
    cfg_we = 1'b0;
    wait_rsp(2, n);
    checks++; if (n != 4) begin errors++; $display("FAIL midcfg_old_latency got %0d want 4", n); end
    e = sb.pop_front();
    checks++; if ({rsp_res0, rsp_res1, rsp_res2} !== e) begin errors++; $display("FAIL midcfg_result got %h want %h", {rsp_res0, rsp_res1, rsp_res2}, e); end
    handshake();
    checks++; if (lat_q !== 4'd9) begin errors++; $display("FAIL midcfg_lat_q got %0d want 9", lat_q); end
    issue(32'hFFFFFFFF, 32'h00000001);
    wait_rsp(1, n);
    checks++; if (n != 11) begin errors++; $display("FAIL midcfg_new_latency got %0d want 11", n); end
    e = sb.pop_front();
    checks++; if ({rsp_res0, rsp_res1, rsp_res2} !== e) begin errors++; $display("FAIL midcfg_result2 got %h want %h", {rsp_res0, rsp_res1, rsp_res2}, e); end
    handshake();
  endtask

  task automatic test_cfg_at_accept();
    int n;
    exp_t e;
    set_lat(1);
    req_opa = 32'h0000BEEF; req_opb = 32'h00001000; req_valid = 1'b1;
    cfg_we = 1'b1; cfg_lat = 4'd3;
    sb.push_back(model(32'h0000BEEF, 32'h00001000));
    @(negedge UserCLK);
    req_valid = 1'b0; cfg_we = 1'b0;
    wait_rsp(1, n);
    checks++; if (n != 3) begin errors++; $display("FAIL acccfg_latency got %0d want 3", n); end
    checks++; if (lat_q !== 4'd3) begin errors++; $display("FAIL acccfg_lat_q got %0d want 3", lat_q); end
    e = sb.pop_front();
    checks++; if ({rsp_res0, rsp_res1, rsp_res2} !== e) begin errors++; $display("FAIL acccfg_result got %h want %h", {rsp_res0, rsp_res1, rsp_res2}, e); end
    handshake();
  endtask

  task automatic test_max_lat();
    int n;
    exp_t e;
    set_lat(4'hF);
    issue(32'h80000000, 32'h7FFFFFFF);
    wait_rsp(1, n);
    checks++; if (n != 17) begin errors++; $display("FAIL maxlat_latency got %0d want 17", n); end
    e = sb.pop_front();
    checks++; if ({rsp_res0, rsp_res1, rsp_res2} !== e) begin errors++; $display("FAIL maxlat_result got %h want %h", {rsp_res0, rsp_res1, rsp_res2}, e); end
    handshake();
  endtask

  task automatic test_reset_abort();
    int seen;
    set_lat(5);
    issue(32'hDEADBEEF, 32'h11111111);
    @(negedge UserCLK);
    reset = 1'b1;
    @(negedge UserCLK);
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL abort_flags got %b want 01", {rsp_valid, req_ready}); end
    checks++; if (fabric_opa !== '0) begin errors++; $display("FAIL abort_fabric_opa got %h want 0", fabric_opa); end
    checks++; if (lat_q !== LAT_W'(LAT_RST)) begin errors++; $display("FAIL abort_lat_q got %0d want %0d", lat_q, LAT_RST); end
    reset = 1'b0;
    sb.delete();
    rsp_ready = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge UserCLK);
      if (rsp_valid) seen++;
    end
    rsp_ready = 1'b0;
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_rsp got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_back_to_back();
    int   n;
    int   hs;
    exp_t e;
    logic [31:0] a, b;
    reset = 1'b1;
    repeat (2) @(negedge UserCLK);
    reset = 1'b0;
    @(negedge UserCLK);
    res_mode = 0;
    rsp_ready = 1'b1;
    hs = 0;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom;
      req_opa = a; req_opb = b; req_valid = 1'b1;
      sb.push_back(model(a, b));
      @(negedge UserCLK);
      n = 1;
      while (!req_ready && n < 40) begin
        if (rsp_valid) begin
          hs++;
          e = sb.pop_front();
          checks++; if ({rsp_res0, rsp_res1, rsp_res2} !== e) begin errors++; $display("FAIL b2b_result[%0d] got %h want %h", i, {rsp_res0, rsp_res1, rsp_res2}, e); end
        end
        @(negedge UserCLK);
        n++;
      end
      checks++; if (n != 4) begin errors++; $display("FAIL b2b_interval[%0d] got %0d want 4", i, n); end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    checks++; if (hs != 3) begin errors++; $display("FAIL b2b_handshakes got %0d want 3", hs); end
`ifdef CPU_FABRIC_OP_PERF_EN
    checks++; if (op_count !== 32'd3) begin errors++; $display("FAIL perf_op_count got %0d want 3", op_count); end
    checks++; if (busy_cycles !== 32'd9) begin errors++; $display("FAIL perf_busy_cycles got %0d want 9", busy_cycles); end
`endif
    @(negedge UserCLK);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lat0();
    test_backpressure();
    test_cfg_midflight();
    test_cfg_at_accept();
    test_max_lat();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
